word_parser: RTL and testbench
==============================

Name: word_parser

Overview:
- Forth input-stream tokenizer (WORD/PARSE).
- Sits directly upstream of the number converter.
- Scans the terminal input buffer (TIB) in byte memory from offset >IN, skips leading delimiters, and locates the next token.
- Returns token start address, token length and updated >IN. The interpreter then hands the token address to dictionary lookup or the number converter.

Parameters:
ASZ, 17, byte-memory address width
LSZ, 8, width of TIB length, offsets and token length (max TIB 2^LSZ-1 bytes)

Ports:
clk      input   1    clock
rst_n    input   1    asynchronous active-low reset
start    input   1    1-cycle request; sampled only in IDLE
tib      input   ASZ  TIB base address
tib_len  input   LSZ  number of valid bytes in TIB (#TIB)
in_ofs   input   LSZ  scan start offset (>IN)
delim    input   8    delimiter character (normally 0x20)
ma       output  ASZ  memory read address
ch       input   8    memory read data; synchronous RAM, ch in cycle t+1 = mem[ma in cycle t]
bsy      output  1    1 while a scan is in progress
done     output  1    1-cycle pulse when results are valid
eol      output  1    1 = no token found (end of buffer or NUL)
tok_adr  output  ASZ  token start address
tok_len  output  LSZ  token length in bytes
in_nxt   output  LSZ  new >IN value

Behaviour:
- Reset (async, rst_n=0): state IDLE; ma, tok_adr, tok_len, in_nxt, pos = 0; bsy, done, eol = 0. Reset asserted mid-scan aborts immediately, with no done pulse.
- Internal registers: pos (LSZ bits) is the TIB offset of the byte currently on ch; latched copies of tib, tib_len and delim.
- Inputs are latched at start. Changes to them during a scan have no effect.
- IDLE:
  - On start: latch inputs, pos <= in_ofs, ma <= tib+in_ofs, bsy <= 1, eol <= 0.
  - If in_ofs >= tib_len: go to DONE with eol=1, tok_len=0, tok_adr=tib+in_ofs, in_nxt=tib_len.
  - Otherwise go to FILL.
  - start while not IDLE is ignored.
- FILL (1 cycle, RAM latency): ma <= ma+1 → SKIP.
- SKIP (one byte per cycle). Priority:
  - pos==tib_len or ch==0: DONE, eol=1, tok_len=0, tok_adr=tib+pos, in_nxt=pos.
  - ch==delim: pos++, ma++.
  - Otherwise: tok_adr <= tib+pos, tok_len <= 1, pos++, ma++ → SCAN.
- SCAN (one byte per cycle). Priority:
  - pos==tib_len or ch==0: DONE, in_nxt=pos.
  - ch==delim: DONE, in_nxt=pos+1 (the trailing delimiter is consumed).
  - Otherwise: tok_len++, pos++, ma++.
- The pos==tib_len check precedes any use of ch. Bytes beyond tib_len are fetched but never interpreted.
- DONE (1 cycle): done=1, bsy <= 0 → IDLE. Reaching DONE from SCAN gives eol=0.
- Result outputs hold until the next start is accepted. eol clears at start.
- done is 0 in all states except DONE. bsy is 1 from the cycle after start through the DONE cycle.
- Latency, with start in cycle 0, S leading delimiters and token length L ≥ 1:
  - terminated by delimiter: done in cycle S+L+3.
  - terminated by end of buffer or NUL: done in cycle S+L+3.
  - empty result: done in cycle S+3, or cycle 1 for in_ofs >= tib_len.
- Arithmetic:
  - tok_adr = tib + zero-extended pos, modulo 2^ASZ.
  - pos never exceeds tib_len, so tok_len and in_nxt cannot overflow LSZ.
  - in_nxt=pos+1 is taken only when pos < tib_len.

Test Plan:
- TIB at 0x100 = "  12 ab", tib_len=7, in_ofs=0, delim=0x20 → done cycle 7, tok_adr=0x102, tok_len=2, in_nxt=5, eol=0; ma steps 0x100..0x106 one per cycle.
- Same TIB, in_ofs=5 → done cycle 5, tok_adr=0x105, tok_len=2, in_nxt=7, eol=0 (terminated by end of buffer).
- Same TIB, in_ofs=7 → done cycle 1, eol=1, tok_len=0, in_nxt=7; TIB "   " with tib_len=3, in_ofs=0 → done cycle 6, eol=1, in_nxt=3.
- TIB "ab\0cd", tib_len=5, in_ofs=0 → tok_len=2, in_nxt=2, eol=0. Then in_ofs=2 → eol=1, in_nxt=2 (NUL stops scan).
- Pulse start again while bsy=1 → ignored, results unchanged. Deassert rst_n in cycle 3 of a scan → all outputs 0 immediately, no done. After release, a new start completes normally.
- TIB at 0x1FFFE = "xyz", tib_len=3, ASZ=17 → ma wraps 0x1FFFF→0x00000, tok_adr=0x1FFFE, tok_len=3, in_nxt=3.

Source files
------------

// File: rtl/word_parser_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | word_parser_if : request/result and byte-memory signals of the       |
// |                  Forth input-stream tokenizer                        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface word_parser_if #(
  parameter int ASZ = 17,
  parameter int LSZ = 8
);
  logic           start;
  logic [ASZ-1:0] tib;
  logic [LSZ-1:0] tib_len;
  logic [LSZ-1:0] in_ofs;
  logic [7:0]     delim;
  logic [ASZ-1:0] ma;
  logic [7:0]     ch;
  logic           bsy;
  logic           done;
  logic           eol;
  logic [ASZ-1:0] tok_adr;
  logic [LSZ-1:0] tok_len;
  logic [LSZ-1:0] in_nxt;

  modport master (
    output start, tib, tib_len, in_ofs, delim, ch,
    input  ma, bsy, done, eol, tok_adr, tok_len, in_nxt
  );

  modport slave (
    input  start, tib, tib_len, in_ofs, delim, ch,
    output ma, bsy, done, eol, tok_adr, tok_len, in_nxt
  );
endinterface
`default_nettype wire

// File: rtl/word_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | word_parser : Forth WORD/PARSE tokenizer, scans the TIB from >IN,     |
// |               skips leading delimiters and returns the next token    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module word_parser #(
  parameter int ASZ = 17,
  parameter int LSZ = 8
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  word_parser_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_SKIP = 3'd2,
    S_SCAN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [LSZ-1:0] c_pos_one = LSZ'(1);
  localparam logic [ASZ-1:0] c_ma_one  = ASZ'(1);

  state_t         r_state;
  logic [ASZ-1:0] r_ma;
  logic [LSZ-1:0] r_pos;
  logic [ASZ-1:0] r_tib;
  logic [LSZ-1:0] r_len;
  logic [7:0]     r_delim;
  logic [ASZ-1:0] r_tok_adr;
  logic [LSZ-1:0] r_tok_len;
  logic [LSZ-1:0] r_in_nxt;
  logic           r_bsy;
  logic           r_eol;

  state_t         w_state_nxt;
  logic [ASZ-1:0] w_ma_nxt;
  logic [LSZ-1:0] w_pos_nxt;
  logic [ASZ-1:0] w_tib_nxt;
  logic [LSZ-1:0] w_len_nxt;
  logic [7:0]     w_delim_nxt;
  logic [ASZ-1:0] w_tok_adr_nxt;
  logic [LSZ-1:0] w_tok_len_nxt;
  logic [LSZ-1:0] w_in_nxt_nxt;
  logic           w_bsy_nxt;
  logic           w_eol_nxt;
  logic           w_end;
  logic           w_is_delim;
  logic [ASZ-1:0] w_pos_adr;

  // End of buffer is tested before ch is trusted; bytes past tib_len are garbage.
  assign w_end      = (r_pos == r_len) || (bus.ch == 8'h00);
  assign w_is_delim = (bus.ch == r_delim);
  assign w_pos_adr  = r_tib + ASZ'(r_pos);

  always_comb begin
    w_state_nxt   = r_state;
    w_ma_nxt      = r_ma;
    w_pos_nxt     = r_pos;
    w_tib_nxt     = r_tib;
    w_len_nxt     = r_len;
    w_delim_nxt   = r_delim;
    w_tok_adr_nxt = r_tok_adr;
    w_tok_len_nxt = r_tok_len;
    w_in_nxt_nxt  = r_in_nxt;
    w_bsy_nxt     = r_bsy;
    w_eol_nxt     = r_eol;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_tib_nxt   = bus.tib;
          w_len_nxt   = bus.tib_len;
          w_delim_nxt = bus.delim;
          w_pos_nxt   = bus.in_ofs;
          w_ma_nxt    = bus.tib + ASZ'(bus.in_ofs);
          w_bsy_nxt   = 1'b1;
          w_eol_nxt   = 1'b0;
          if (bus.in_ofs >= bus.tib_len) begin
            w_state_nxt   = S_DONE;
            w_eol_nxt     = 1'b1;
            w_tok_len_nxt = '0;
            w_tok_adr_nxt = bus.tib + ASZ'(bus.in_ofs);
            w_in_nxt_nxt  = bus.tib_len;
          end else begin
            w_state_nxt = S_FILL;
          end
        end
      end

      // Covers the one-cycle read latency so ch lines up with pos in SKIP.
      S_FILL: begin
        w_ma_nxt    = r_ma + c_ma_one;
        w_state_nxt = S_SKIP;
      end

      S_SKIP: begin
        if (w_end) begin
          w_state_nxt   = S_DONE;
          w_eol_nxt     = 1'b1;
          w_tok_len_nxt = '0;
          w_tok_adr_nxt = w_pos_adr;
          w_in_nxt_nxt  = r_pos;
        end else if (w_is_delim) begin
          w_pos_nxt = r_pos + c_pos_one;
          w_ma_nxt  = r_ma + c_ma_one;
        end else begin
          w_tok_adr_nxt = w_pos_adr;
          w_tok_len_nxt = c_pos_one;
          w_pos_nxt     = r_pos + c_pos_one;
          w_ma_nxt      = r_ma + c_ma_one;
          w_state_nxt   = S_SCAN;
        end
      end

      S_SCAN: begin
        if (w_end) begin
          w_state_nxt  = S_DONE;
          w_in_nxt_nxt = r_pos;
        end else if (w_is_delim) begin
          w_state_nxt  = S_DONE;
          w_in_nxt_nxt = r_pos + c_pos_one;
        end else begin
          w_tok_len_nxt = r_tok_len + c_pos_one;
          w_pos_nxt     = r_pos + c_pos_one;
          w_ma_nxt      = r_ma + c_ma_one;
        end
      end

      S_DONE: begin
        w_bsy_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ma      <= '0;
      r_pos     <= '0;
      r_tib     <= '0;
      r_len     <= '0;
      r_delim   <= '0;
      r_tok_adr <= '0;
      r_tok_len <= '0;
      r_in_nxt  <= '0;
      r_bsy     <= 1'b0;
      r_eol     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ma      <= w_ma_nxt;
      r_pos     <= w_pos_nxt;
      r_tib     <= w_tib_nxt;
      r_len     <= w_len_nxt;
      r_delim   <= w_delim_nxt;
      r_tok_adr <= w_tok_adr_nxt;
      r_tok_len <= w_tok_len_nxt;
      r_in_nxt  <= w_in_nxt_nxt;
      r_bsy     <= w_bsy_nxt;
      r_eol     <= w_eol_nxt;
    end
  end

  assign bus.ma      = r_ma;
  assign bus.bsy     = r_bsy;
  assign bus.done    = (r_state == S_DONE);
  assign bus.eol     = r_eol;
  assign bus.tok_adr = r_tok_adr;
  assign bus.tok_len = r_tok_len;
  assign bus.in_nxt  = r_in_nxt;

endmodule
`default_nettype wire

// File: tb/tb_word_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_word_parser : directed self-checking bench for word_parser        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_word_parser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [16:0] ma_log [0:63];
  logic [7:0]  mem [0:131071];

  always #5 clk = ~clk;

  word_parser_if #(.ASZ(17), .LSZ(8)) bus ();

  word_parser #(.ASZ(17), .LSZ(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) bus.ch <= mem[bus.ma];

  task automatic put(input logic [16:0] a, input logic [7:0] b);
    mem[a] = b;
  endtask

  // start in cycle 0; returns the cycle in which done is seen, or -1 on timeout
  task automatic do_scan(input logic [16:0] t, input logic [7:0] l, input logic [7:0] o,
                         input logic [7:0] d, output int cyc);
    @(negedge clk);
    bus.tib = t; bus.tib_len = l; bus.in_ofs = o; bus.delim = d; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      ma_log[k] = bus.ma;
      if (bus.done === 1'b1) begin cyc = k; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.bsy !== 1'b0) begin n_bad++; $display("FAIL rst_bsy: got %b want 0", bus.bsy); end
    n_cmp++; if (bus.eol !== 1'b0) begin n_bad++; $display("FAIL rst_eol: got %b want 0", bus.eol); end
    n_cmp++; if (bus.ma !== 17'h0) begin n_bad++; $display("FAIL rst_ma: got %h want 0", bus.ma); end
    n_cmp++; if ({bus.tok_adr, bus.tok_len, bus.in_nxt} !== 33'h0) begin n_bad++;
      $display("FAIL rst_results: got %h/%h/%h want 0/0/0", bus.tok_adr, bus.tok_len, bus.in_nxt); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int cyc;
    do_scan(17'h100, 8'd7, 8'd0, 8'h20, cyc);
    n_cmp++; if (cyc !== 7) begin n_bad++; $display("FAIL basic_cycle: got %0d want 7", cyc); end
    n_cmp++; if (bus.tok_adr !== 17'h102) begin n_bad++; $display("FAIL basic_adr: got %h want 102", bus.tok_adr); end
    n_cmp++; if (bus.tok_len !== 8'd2) begin n_bad++; $display("FAIL basic_len: got %0d want 2", bus.tok_len); end
    n_cmp++; if (bus.in_nxt !== 8'd5) begin n_bad++; $display("FAIL basic_in: got %0d want 5", bus.in_nxt); end
    n_cmp++; if (bus.eol !== 1'b0) begin n_bad++; $display("FAIL basic_eol: got %b want 0", bus.eol); end
    n_cmp++; if (bus.bsy !== 1'b1) begin n_bad++; $display("FAIL basic_bsy_done: got %b want 1", bus.bsy); end
    for (int k = 1; k <= 6; k++) begin
      n_cmp++; if (ma_log[k] !== 17'h100 + 17'(k - 1)) begin n_bad++;
        $display("FAIL basic_ma_c%0d: got %h want %h", k, ma_log[k], 17'h100 + 17'(k - 1)); end
    end
    @(negedge clk);
    n_cmp++; if ({bus.bsy, bus.done} !== 2'b00) begin n_bad++; $display("FAIL basic_after: bsy/done got %b want 00", {bus.bsy, bus.done}); end
    n_cmp++; if (bus.tok_len !== 8'd2) begin n_bad++; $display("FAIL basic_hold: got %0d want 2", bus.tok_len); end
  endtask

  task automatic test_end_of_buffer;
    int cyc;
    do_scan(17'h100, 8'd7, 8'd5, 8'h20, cyc);
    n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL eob_cycle: got %0d want 5", cyc); end
    n_cmp++; if (bus.tok_adr !== 17'h105) begin n_bad++; $display("FAIL eob_adr: got %h want 105", bus.tok_adr); end
    n_cmp++; if (bus.tok_len !== 8'd2) begin n_bad++; $display("FAIL eob_len: got %0d want 2", bus.tok_len); end
    n_cmp++; if (bus.in_nxt !== 8'd7) begin n_bad++; $display("FAIL eob_in: got %0d want 7", bus.in_nxt); end
    n_cmp++; if (bus.eol !== 1'b0) begin n_bad++; $display("FAIL eob_eol: got %b want 0", bus.eol); end
  endtask

  task automatic test_empty;
    int cyc;
    do_scan(17'h100, 8'd7, 8'd7, 8'h20, cyc);
    n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL empty_ofs_cycle: got %0d want 1", cyc); end
    n_cmp++; if ({bus.eol, bus.tok_len, bus.in_nxt} !== {1'b1, 8'd0, 8'd7}) begin n_bad++;
      $display("FAIL empty_ofs_res: eol/len/in got %b/%0d/%0d want 1/0/7", bus.eol, bus.tok_len, bus.in_nxt); end
    n_cmp++; if (bus.tok_adr !== 17'h107) begin n_bad++; $display("FAIL empty_ofs_adr: got %h want 107", bus.tok_adr); end
    do_scan(17'h300, 8'd3, 8'd0, 8'h20, cyc);
    n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL blanks_cycle: got %0d want 6", cyc); end
    n_cmp++; if ({bus.eol, bus.tok_len, bus.in_nxt} !== {1'b1, 8'd0, 8'd3}) begin n_bad++;
      $display("FAIL blanks_res: eol/len/in got %b/%0d/%0d want 1/0/3", bus.eol, bus.tok_len, bus.in_nxt); end
  endtask

  task automatic test_nul;
    int cyc;
    do_scan(17'h200, 8'd5, 8'd0, 8'h20, cyc);
    n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL nul_cycle: got %0d want 5", cyc); end
    n_cmp++; if ({bus.eol, bus.tok_len, bus.in_nxt} !== {1'b0, 8'd2, 8'd2}) begin n_bad++;
      $display("FAIL nul_res: eol/len/in got %b/%0d/%0d want 0/2/2", bus.eol, bus.tok_len, bus.in_nxt); end
    do_scan(17'h200, 8'd5, 8'd2, 8'h20, cyc);
    n_cmp++; if (cyc !== 3) begin n_bad++; $display("FAIL nul2_cycle: got %0d want 3", cyc); end
    n_cmp++; if ({bus.eol, bus.tok_len, bus.in_nxt} !== {1'b1, 8'd0, 8'd2}) begin n_bad++;
      $display("FAIL nul2_res: eol/len/in got %b/%0d/%0d want 1/0/2", bus.eol, bus.tok_len, bus.in_nxt); end
    n_cmp++; if (bus.tok_adr !== 17'h202) begin n_bad++; $display("FAIL nul2_adr: got %h want 202", bus.tok_adr); end
  endtask

  task automatic test_start_while_busy;
    int cyc;
    @(negedge clk);
    bus.tib = 17'h100; bus.tib_len = 8'd7; bus.in_ofs = 8'd0; bus.delim = 8'h20; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    bus.tib = 17'h300; bus.tib_len = 8'd3; bus.in_ofs = 8'd1; bus.delim = 8'h31; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    cyc = -1;
    for (int k = 3; k <= 40; k++) begin
      if (bus.done === 1'b1) begin cyc = k; break; end
      @(negedge clk);
    end
    n_cmp++; if (cyc !== 7) begin n_bad++; $display("FAIL busy_cycle: got %0d want 7", cyc); end
    n_cmp++; if ({bus.tok_adr, bus.tok_len, bus.in_nxt} !== {17'h102, 8'd2, 8'd5}) begin n_bad++;
      $display("FAIL busy_res: adr/len/in got %h/%0d/%0d want 102/2/5", bus.tok_adr, bus.tok_len, bus.in_nxt); end
    @(negedge clk);
    n_cmp++; if (bus.bsy !== 1'b0) begin n_bad++; $display("FAIL busy_idle: got %b want 0", bus.bsy); end
  endtask

  task automatic test_reset_mid_scan;
    int cyc;
    bit saw_done;
    @(negedge clk);
    bus.tib = 17'h100; bus.tib_len = 8'd7; bus.in_ofs = 8'd0; bus.delim = 8'h20; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.bsy, bus.done, bus.eol} !== 3'b000) begin n_bad++; $display("FAIL abort_flags: got %b want 000", {bus.bsy, bus.done, bus.eol}); end
    n_cmp++; if ({bus.ma, bus.tok_adr, bus.tok_len, bus.in_nxt} !== 50'h0) begin n_bad++;
      $display("FAIL abort_vals: ma/adr/len/in got %h/%h/%h/%h want 0", bus.ma, bus.tok_adr, bus.tok_len, bus.in_nxt); end
    saw_done = 1'b0;
    repeat (2) begin @(negedge clk); if (bus.done !== 1'b0) saw_done = 1'b1; end
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); if (bus.done !== 1'b0) saw_done = 1'b1; end
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL abort_nodone: got %b want 0", saw_done); end
    do_scan(17'h100, 8'd7, 8'd0, 8'h20, cyc);
    n_cmp++; if (cyc !== 7) begin n_bad++; $display("FAIL rerun_cycle: got %0d want 7", cyc); end
    n_cmp++; if ({bus.tok_adr, bus.tok_len, bus.in_nxt} !== {17'h102, 8'd2, 8'd5}) begin n_bad++;
      $display("FAIL rerun_res: adr/len/in got %h/%0d/%0d want 102/2/5", bus.tok_adr, bus.tok_len, bus.in_nxt); end
  endtask

  task automatic test_wrap;
    int cyc;
    do_scan(17'h1FFFE, 8'd3, 8'd0, 8'h20, cyc);
    n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL wrap_cycle: got %0d want 6", cyc); end
    n_cmp++; if ({ma_log[2], ma_log[3]} !== {17'h1FFFF, 17'h00000}) begin n_bad++;
      $display("FAIL wrap_ma: got %h,%h want 1ffff,00000", ma_log[2], ma_log[3]); end
    n_cmp++; if ({bus.tok_adr, bus.tok_len, bus.in_nxt, bus.eol} !== {17'h1FFFE, 8'd3, 8'd3, 1'b0}) begin n_bad++;
      $display("FAIL wrap_res: adr/len/in/eol got %h/%0d/%0d/%b want 1fffe/3/3/0", bus.tok_adr, bus.tok_len, bus.in_nxt, bus.eol); end
  endtask

  initial begin
    bus.start = 1'b0; bus.tib = '0; bus.tib_len = '0; bus.in_ofs = '0; bus.delim = 8'h20;
    put(17'h100, 8'h20); put(17'h101, 8'h20); put(17'h102, 8'h31); put(17'h103, 8'h32);
    put(17'h104, 8'h20); put(17'h105, 8'h61); put(17'h106, 8'h62); put(17'h107, 8'h20);
    put(17'h200, 8'h61); put(17'h201, 8'h62); put(17'h202, 8'h00); put(17'h203, 8'h63);
    put(17'h204, 8'h64);
    put(17'h300, 8'h20); put(17'h301, 8'h20); put(17'h302, 8'h20); put(17'h303, 8'h41);
    put(17'h1FFFE, 8'h78); put(17'h1FFFF, 8'h79); put(17'h00000, 8'h7A); put(17'h00001, 8'h20);
    test_reset;
    test_basic;
    test_end_of_buffer;
    test_empty;
    test_nul;
    test_start_while_busy;
    test_reset_mid_scan;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
